regfile_wrport_arb: RTL and testbench
=====================================

// Module: regfile_wrport_arb
// PURPOSE
//  Shares the single register-file write port (wb2regfile_*) between the in-order pipeline writeback and a
//  long-latency unit (divider/LSU miss return). Long-latency results queue in a small FIFO. A scoreboard of
//  pending destinations stalls decode on RAW/WAW hazards against in-flight long-latency ops. Sits between
//  the mem/wb stage, the long-latency unit and the regfile, beside the decode stall logic.
// PARAMETERS
//  XLEN       32  data width
//  LQ_DEPTH   2   long-latency result FIFO entries (power of 2, >=2)
//  STARVE_MAX 8   cycles a non-empty FIFO head may wait before pipe_hold asserts
// PORTS
//  clk                    in   1     clock
//  cpurst_n               in   1     asynchronous active-low reset
//  pipe_wr_reg            in   1     pipeline writeback request
//  pipe_wr_regindex       in   5     pipeline destination
//  pipe_wr_wdata          in   XLEN  pipeline write data
//  pipe_hold              out  1     pipeline must present no write this cycle (starvation drain)
//  lu_issue               in   1     long-latency op issued this cycle
//  lu_issue_regindex      in   5     its destination
//  lu_rsp_valid           in   1     long-latency result valid
//  lu_rsp_regindex        in   5     result destination
//  lu_rsp_wdata           in   XLEN  result data
//  lu_rsp_ready           out  1     FIFO can accept a result
//  rs1_addr,rs2_addr,rs3_addr in 5 each  decode source indices
//  de_wr_reg              in   1     decode instruction writes rd
//  de_rd_addr             in   5     decode destination
//  de_stall               out  1     decode must stall (hazard on pending register)
//  wb2regfile_wr_reg      out  1     regfile write enable
//  wb2regfile_wr_regindex out  5     regfile write index
//  wb2regfile_wr_wdata    out  XLEN  regfile write data
// BEHAVIOUR
//  Reset (async, cpurst_n=0): FIFO empty, pending[31:1]=0, starve counter=0, pipe_hold=0; hence
//   lu_rsp_ready=1, de_stall=0, wb2regfile_wr_reg=0, index/data=0. Reset mid-operation discards queued results.
//  FIFO: push on lu_rsp_valid&lu_rsp_ready; lu_rsp_ready=!full (no push-when-full even if popping).
//   No bypass: a result accepted at edge N is written to the regfile no earlier than cycle N+1.
//   Pointers wrap modulo LQ_DEPTH; occupancy counter distinguishes full/empty.
//  Port arbitration (combinational, same cycle):
//   1) pipe_wr_reg=1 & pipe_wr_regindex!=0 -> pipeline owns port (always wins, even when pipe_hold=1).
//   2) else FIFO non-empty -> pop head, drive its index/data, wr_reg=1.
//   3) else wr_reg=0, index/data=0. Pipeline write to x0 counts as idle (FIFO may use port).
//  Starvation: counter increments each cycle FIFO non-empty and head not popped; clears on pop or empty.
//   pipe_hold is registered: set at the edge the counter reaches STARVE_MAX, cleared at the edge after
//   a pop. Counter saturates at STARVE_MAX.
//  Scoreboard pending[31:1]:
//   set at edge on lu_issue & lu_issue_regindex!=0; clear at the edge a FIFO entry is written to the regfile
//   (same edge the regfile latches it) for that index. Same-index set+clear in one cycle -> set wins.
//   Index 0 never pending. lu_rsp for a non-pending index is still written (no check).
//  de_stall (combinational) = pending[rs1]|pending[rs2]|pending[rs3] (nonzero indices only)
//   | (de_wr_reg & pending[de_rd_addr]). Bit clearing at edge N removes stall in cycle N+1.
//  Pipeline write to a pending index cannot occur (WAW stall); no ordering check is made in this block.
// TESTING
//  1) Reset; lu_rsp x5=0xAAAA_0001 with pipeline idle -> lu_rsp_ready=1; next cycle wb2regfile x5/0xAAAA_0001, wr_reg=1.
//  2) lu_issue x7; decode rs2=7 -> de_stall=1 until the cycle after x7 result writes; rs2=0 never stalls.
//  3) Pipeline writes every cycle, 2 results queued (full) -> lu_rsp_ready=0; pipe_hold=1 after 8 waiting
//     cycles; with pipe idle, head pops, pipe_hold drops next cycle, ready=1.
//  4) Same cycle: pipe write x3=0x11 and FIFO head x4 -> x3 written, x4 written next idle cycle, order kept.
//  5) Pipeline write to x0 with FIFO non-empty -> FIFO head written that cycle.
//  6) Assert cpurst_n=0 with FIFO full and pending bits set -> all outputs to reset values immediately, stall=0.

Source files
------------

// File: rtl/regfile_wrport_arb.sv
// regfile_wrport_arb: shares the single regfile write port between the in-order
// pipeline writeback and a long-latency unit. Long-latency results wait in a small
// FIFO, and a scoreboard of pending destinations stalls decode on RAW/WAW hazards.
module regfile_wrport_arb #(
  parameter int XLEN       = 32,
  parameter int LQ_DEPTH   = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic            clk,
  input  logic            cpurst_n,
  input  logic            pipe_wr_reg,
  input  logic [4:0]      pipe_wr_regindex,
  input  logic [XLEN-1:0] pipe_wr_wdata,
  output logic            pipe_hold,
  input  logic            lu_issue,
  input  logic [4:0]      lu_issue_regindex,
  input  logic            lu_rsp_valid,
  input  logic [4:0]      lu_rsp_regindex,
  input  logic [XLEN-1:0] lu_rsp_wdata,
  output logic            lu_rsp_ready,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  input  logic [4:0]      rs3_addr,
  input  logic            de_wr_reg,
  input  logic [4:0]      de_rd_addr,
  output logic            de_stall,
  output logic            wb2regfile_wr_reg,
  output logic [4:0]      wb2regfile_wr_regindex,
  output logic [XLEN-1:0] wb2regfile_wr_wdata
);

  localparam int PTR_W = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int ST_W  = $clog2(STARVE_MAX + 1);

  // FIFO storage and pointers
  logic [4:0]      mem_idx_q  [LQ_DEPTH];
  logic [4:0]      mem_idx_d  [LQ_DEPTH];
  logic [XLEN-1:0] mem_data_q [LQ_DEPTH];
  logic [XLEN-1:0] mem_data_d [LQ_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Starvation tracking and scoreboard
  logic [ST_W-1:0] starve_q, starve_d;
  logic            hold_q, hold_d;
  logic [31:0]     pending_q, pending_d;

  // Arbitration helpers
  logic            pipe_own;
  logic            fifo_empty;
  logic            fifo_full;
  logic            push;
  logic            pop;
  logic [4:0]      head_idx;
  logic [XLEN-1:0] head_data;

  // Decide who owns the write port this cycle; a pipeline write to x0 counts as idle
  always_comb begin
    pipe_own   = pipe_wr_reg && (pipe_wr_regindex != 5'd0);
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CNT_W'(LQ_DEPTH));
    push       = lu_rsp_valid && !fifo_full;
    pop        = !pipe_own && !fifo_empty;
    head_idx   = mem_idx_q[rd_ptr_q];
    head_data  = mem_data_q[rd_ptr_q];
  end

  // Drive the regfile write port and handshake outputs
  always_comb begin
    wb2regfile_wr_reg      = 1'b0;
    wb2regfile_wr_regindex = 5'd0;
    wb2regfile_wr_wdata    = '0;
    if (pipe_own) begin
      wb2regfile_wr_reg      = 1'b1;
      wb2regfile_wr_regindex = pipe_wr_regindex;
      wb2regfile_wr_wdata    = pipe_wr_wdata;
    end else if (pop) begin
      wb2regfile_wr_reg      = 1'b1;
      wb2regfile_wr_regindex = head_idx;
      wb2regfile_wr_wdata    = head_data;
    end
    lu_rsp_ready = !fifo_full;
    pipe_hold    = hold_q;
  end

  // Next FIFO contents, pointers and occupancy; full blocks a push even while popping
  always_comb begin
    mem_idx_d  = mem_idx_q;
    mem_data_d = mem_data_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push) begin
      mem_idx_d[wr_ptr_q]  = lu_rsp_regindex;
      mem_data_d[wr_ptr_q] = lu_rsp_wdata;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Count cycles the FIFO head waits; hold the pipeline once the wait hits the limit
  always_comb begin
    starve_d = starve_q;
    hold_d   = hold_q;
    if (fifo_empty || pop) begin
      starve_d = '0;
    end else if (starve_q < ST_W'(STARVE_MAX)) begin
      starve_d = starve_q + ST_W'(1);
    end
    if (pop) begin
      hold_d = 1'b0;
    end else if (starve_d == ST_W'(STARVE_MAX)) begin
      hold_d = 1'b1;
    end
  end

  // Scoreboard update: a new issue to the same index overrides the retiring clear
  always_comb begin
    pending_d = pending_q;
    if (pop && (head_idx != 5'd0)) begin
      pending_d[head_idx] = 1'b0;
    end
    if (lu_issue && (lu_issue_regindex != 5'd0)) begin
      pending_d[lu_issue_regindex] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // Decode hazard check against registers still owed by the long-latency unit
  always_comb begin
    de_stall = ((rs1_addr != 5'd0) && pending_q[rs1_addr])
            || ((rs2_addr != 5'd0) && pending_q[rs2_addr])
            || ((rs3_addr != 5'd0) && pending_q[rs3_addr])
            || (de_wr_reg && (de_rd_addr != 5'd0) && pending_q[de_rd_addr]);
  end

  // State registers; reset discards any queued results and pending bits
  always_ff @(posedge clk or negedge cpurst_n) begin
    if (!cpurst_n) begin
      for (int i = 0; i < LQ_DEPTH; i++) begin
        mem_idx_q[i]  <= 5'd0;
        mem_data_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      starve_q  <= '0;
      hold_q    <= 1'b0;
      pending_q <= '0;
    end else begin
      mem_idx_q  <= mem_idx_d;
      mem_data_q <= mem_data_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      hold_q     <= hold_d;
      pending_q  <= pending_d;
    end
  end

endmodule

// File: tb/tb_regfile_wrport_arb.sv
// tb_regfile_wrport_arb: directed checks of the write-port arbiter, FIFO,
// starvation hold and decode scoreboard.
module tb_regfile_wrport_arb;

  logic        clk;
  logic        cpurst_n;
  logic        pipe_wr_reg;
  logic [4:0]  pipe_wr_regindex;
  logic [31:0] pipe_wr_wdata;
  logic        pipe_hold;
  logic        lu_issue;
  logic [4:0]  lu_issue_regindex;
  logic        lu_rsp_valid;
  logic [4:0]  lu_rsp_regindex;
  logic [31:0] lu_rsp_wdata;
  logic        lu_rsp_ready;
  logic [4:0]  rs1_addr, rs2_addr, rs3_addr;
  logic        de_wr_reg;
  logic [4:0]  de_rd_addr;
  logic        de_stall;
  logic        wb2regfile_wr_reg;
  logic [4:0]  wb2regfile_wr_regindex;
  logic [31:0] wb2regfile_wr_wdata;

  int tests_run    = 0;
  int tests_failed = 0;

  regfile_wrport_arb #(.XLEN(32), .LQ_DEPTH(2), .STARVE_MAX(8)) dut (
    .clk                    (clk),
    .cpurst_n               (cpurst_n),
    .pipe_wr_reg            (pipe_wr_reg),
    .pipe_wr_regindex       (pipe_wr_regindex),
    .pipe_wr_wdata          (pipe_wr_wdata),
    .pipe_hold              (pipe_hold),
    .lu_issue               (lu_issue),
    .lu_issue_regindex      (lu_issue_regindex),
    .lu_rsp_valid           (lu_rsp_valid),
    .lu_rsp_regindex        (lu_rsp_regindex),
    .lu_rsp_wdata           (lu_rsp_wdata),
    .lu_rsp_ready           (lu_rsp_ready),
    .rs1_addr               (rs1_addr),
    .rs2_addr               (rs2_addr),
    .rs3_addr               (rs3_addr),
    .de_wr_reg              (de_wr_reg),
    .de_rd_addr             (de_rd_addr),
    .de_stall               (de_stall),
    .wb2regfile_wr_reg      (wb2regfile_wr_reg),
    .wb2regfile_wr_regindex (wb2regfile_wr_regindex),
    .wb2regfile_wr_wdata    (wb2regfile_wr_wdata)
  );

  // Free-running clock, 10 time-unit period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive the pipeline writeback and long-latency response inputs
  task automatic applyStimulus(input logic p_wr, input logic [4:0] p_idx, input logic [31:0] p_data,
                               input logic r_v, input logic [4:0] r_idx, input logic [31:0] r_data);
    pipe_wr_reg      = p_wr;
    pipe_wr_regindex = p_idx;
    pipe_wr_wdata    = p_data;
    lu_rsp_valid     = r_v;
    lu_rsp_regindex  = r_idx;
    lu_rsp_wdata     = r_data;
  endtask

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge, then settle inputs
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Check the full write port in one call
  task automatic checkPort(input string tag, input logic we, input logic [4:0] idx, input logic [31:0] data);
    checkOutput({tag, ".we"},   {31'd0, wb2regfile_wr_reg}, {31'd0, we});
    checkOutput({tag, ".idx"},  {27'd0, wb2regfile_wr_regindex}, {27'd0, idx});
    checkOutput({tag, ".data"}, wb2regfile_wr_wdata, data);
  endtask

  // Directed sequence
  initial begin
    cpurst_n          = 1'b0;
    lu_issue          = 1'b0;
    lu_issue_regindex = 5'd0;
    rs1_addr          = 5'd0;
    rs2_addr          = 5'd0;
    rs3_addr          = 5'd0;
    de_wr_reg         = 1'b0;
    de_rd_addr        = 5'd0;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    checkOutput("rst.ready", {31'd0, lu_rsp_ready}, 32'd1);
    checkOutput("rst.hold",  {31'd0, pipe_hold},    32'd0);
    checkOutput("rst.stall", {31'd0, de_stall},     32'd0);
    checkPort("rst", 1'b0, 5'd0, 32'h0);
    step();
    cpurst_n = 1'b1;

    // Test 1: single result, no bypass, written the following cycle
    step();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hAAAA_0001);
    #1;
    checkOutput("t1.ready", {31'd0, lu_rsp_ready}, 32'd1);
    checkPort("t1.nobypass", 1'b0, 5'd0, 32'h0);
    step();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    checkPort("t1.write", 1'b1, 5'd5, 32'hAAAA_0001);
    step();
    #1;
    checkPort("t1.drained", 1'b0, 5'd0, 32'h0);

    // Test 2: scoreboard on x7, WAW via decode rd, set-wins on same-index retire
    lu_issue = 1'b1; lu_issue_regindex = 5'd7; rs2_addr = 5'd7;
    #1;
    checkOutput("t2.notyet", {31'd0, de_stall}, 32'd0);
    step();
    lu_issue = 1'b0;
    #1;
    checkOutput("t2.raw", {31'd0, de_stall}, 32'd1);
    rs2_addr = 5'd0;
    #1;
    checkOutput("t2.rs0", {31'd0, de_stall}, 32'd0);
    de_wr_reg = 1'b1; de_rd_addr = 5'd7;
    #1;
    checkOutput("t2.waw", {31'd0, de_stall}, 32'd1);
    de_wr_reg = 1'b0; de_rd_addr = 5'd0; rs2_addr = 5'd7;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h77);
    step();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    lu_issue = 1'b1; lu_issue_regindex = 5'd7;
    #1;
    checkPort("t2.wr7", 1'b1, 5'd7, 32'h77);
    checkOutput("t2.stall_wr", {31'd0, de_stall}, 32'd1);
    step();
    lu_issue = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h78);
    #1;
    checkOutput("t2.setwins", {31'd0, de_stall}, 32'd1);
    step();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    checkPort("t2.wr7b", 1'b1, 5'd7, 32'h78);
    checkOutput("t2.stall_wr2", {31'd0, de_stall}, 32'd1);
    step();
    #1;
    checkOutput("t2.cleared", {31'd0, de_stall}, 32'd0);
    rs2_addr = 5'd0;

    // Test 3: starvation with a full FIFO; head x10 waits D1..D8, hold visible in D9
    applyStimulus(1'b1, 5'd1, 32'h100, 1'b1, 5'd10, 32'hA10);        // D0
    #1;
    checkPort("t3.pipe", 1'b1, 5'd1, 32'h100);
    step();
    applyStimulus(1'b1, 5'd1, 32'h100, 1'b1, 5'd11, 32'hA11);        // D1
    #1;
    checkOutput("t3.ready1", {31'd0, lu_rsp_ready}, 32'd1);
    step();
    applyStimulus(1'b1, 5'd1, 32'h100, 1'b1, 5'd12, 32'hA12);        // D2
    #1;
    checkOutput("t3.full", {31'd0, lu_rsp_ready}, 32'd0);
    for (int d = 3; d <= 8; d++) step();                              // D8
    #1;
    checkOutput("t3.hold_pre", {31'd0, pipe_hold}, 32'd0);
    step();                                                           // D9
    #1;
    checkOutput("t3.hold", {31'd0, pipe_hold}, 32'd1);
    checkPort("t3.pipewins", 1'b1, 5'd1, 32'h100);
    step();                                                           // D10
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'hA12);
    #1;
    checkPort("t3.pop10", 1'b1, 5'd10, 32'hA10);
    checkOutput("t3.nopushfull", {31'd0, lu_rsp_ready}, 32'd0);
    step();                                                           // D11
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    checkOutput("t3.hold_drop", {31'd0, pipe_hold}, 32'd0);
    checkOutput("t3.ready2", {31'd0, lu_rsp_ready}, 32'd1);
    checkPort("t3.pop11", 1'b1, 5'd11, 32'hA11);
    step();                                                           // D12
    #1;
    checkPort("t3.empty", 1'b0, 5'd0, 32'h0);

    // Test 4: pipeline x3 wins over FIFO head x4, x4 follows next idle cycle
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h44);
    step();
    applyStimulus(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'h0);
    #1;
    checkPort("t4.x3", 1'b1, 5'd3, 32'h11);
    step();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    checkPort("t4.x4", 1'b1, 5'd4, 32'h44);
    step();

    // Test 5: pipeline write to x0 counts as idle
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99);
    step();
    applyStimulus(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'h0);
    #1;
    checkPort("t5.x9", 1'b1, 5'd9, 32'h99);
    step();
    #1;
    checkPort("t5.x0idle", 1'b0, 5'd0, 32'h0);

    // Test 6: async reset with FIFO full and pending bits set
    lu_issue = 1'b1; lu_issue_regindex = 5'd12;
    applyStimulus(1'b1, 5'd1, 32'h100, 1'b1, 5'd20, 32'h20);
    step();
    lu_issue_regindex = 5'd13;
    applyStimulus(1'b1, 5'd1, 32'h100, 1'b1, 5'd21, 32'h21);
    step();
    lu_issue = 1'b0;
    applyStimulus(1'b1, 5'd1, 32'h100, 1'b0, 5'd0, 32'h0);
    rs1_addr = 5'd12; rs3_addr = 5'd13;
    #1;
    checkOutput("t6.full", {31'd0, lu_rsp_ready}, 32'd0);
    checkOutput("t6.stall", {31'd0, de_stall}, 32'd1);
    cpurst_n = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    checkOutput("t6.rst_ready", {31'd0, lu_rsp_ready}, 32'd1);
    checkOutput("t6.rst_stall", {31'd0, de_stall}, 32'd0);
    checkOutput("t6.rst_hold",  {31'd0, pipe_hold}, 32'd0);
    checkPort("t6.rst", 1'b0, 5'd0, 32'h0);
    step();
    cpurst_n = 1'b1;
    step();
    #1;
    checkPort("t6.discarded", 1'b0, 5'd0, 32'h0);
    checkOutput("t6.post_stall", {31'd0, de_stall}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
